// File: rtl/calc_seq_ctrl.sv
// Calculator operation sequencer: A -> OP -> B -> EXEC -> SHOW/ERR on Enter edges,
// with Clear from any state and a bounded wait for the ALU.
module calc_seq_ctrl #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_enter,
    input  logic         btn_clr,
    input  logic [W-1:0] sw_data,
    input  logic [1:0]   sw_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic         alu_err,
    input  logic [W-1:0] alu_res,
    output logic [W-1:0] disp_val,
    output logic [2:0]   state_o,
    output logic         err
);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic          btn_prev, clr_prev;
    logic          enter_pulse, clr_pulse;
    logic [CW-1:0] cnt;
    logic [W-1:0]  res_q;
    logic          div_zero, cnt_expired;
    logic          ld_a, ld_op, ld_b, ld_res, start_nxt;
    logic [W-1:0]  disp_nxt;

    assign enter_pulse = btn_enter & ~btn_prev;
    assign clr_pulse   = btn_clr & ~clr_prev;
    assign div_zero    = (alu_op == 2'b11) && (sw_data == '0);
    assign cnt_expired = (cnt == CNT_LAST);
    assign state_o     = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_A;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_pulse) begin
            state_nxt = S_A;
        end else begin
            case (state)
                S_A:    if (enter_pulse) state_nxt = S_OP;
                S_OP:   if (enter_pulse) state_nxt = S_B;
                S_B:    if (enter_pulse) state_nxt = div_zero ? S_ERR : S_EXEC;
                // A done arriving in the expiry cycle takes priority over the timeout.
                S_EXEC: begin
                    if (alu_done)         state_nxt = alu_err ? S_ERR : S_SHOW;
                    else if (cnt_expired) state_nxt = S_ERR;
                end
                S_SHOW: if (enter_pulse) state_nxt = S_A;
                S_ERR:  if (enter_pulse) state_nxt = S_A;
                default: state_nxt = S_A;
            endcase
        end
    end

    always_comb begin
        ld_a      = 1'b0;
        ld_op     = 1'b0;
        ld_b      = 1'b0;
        ld_res    = 1'b0;
        start_nxt = 1'b0;
        disp_nxt  = '0;
        if (!clr_pulse) begin
            ld_a      = (state == S_A)  && enter_pulse;
            ld_op     = (state == S_OP) && enter_pulse;
            ld_b      = (state == S_B)  && enter_pulse;
            start_nxt = (state == S_B)  && enter_pulse && !div_zero;
            ld_res    = (state == S_EXEC) && alu_done && !alu_err;
        end
        case (state)
            S_A, S_B: disp_nxt = sw_data;
            S_OP:     disp_nxt[1:0] = sw_op;
            S_EXEC:   disp_nxt = alu_a;
            S_SHOW:   disp_nxt = res_q;
            S_ERR:    disp_nxt = '1;
            default:  disp_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev  <= 1'b1;
            clr_prev  <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_q     <= '0;
            disp_val  <= '0;
            alu_start <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            btn_prev  <= btn_enter;
            clr_prev  <= btn_clr;
            alu_start <= start_nxt;
            disp_val  <= disp_nxt;
            err       <= (state_nxt == S_ERR);
            cnt       <= (state == S_EXEC) ? cnt + CW'(1) : '0;
            if (clr_pulse) begin
                alu_a  <= '0;
                alu_b  <= '0;
                alu_op <= '0;
                res_q  <= '0;
            end else begin
                if (ld_a)   alu_a  <= sw_data;
                if (ld_op)  alu_op <= sw_op;
                if (ld_b)   alu_b  <= sw_data;
                if (ld_res) res_q  <= alu_res;
            end
        end
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Operation sequencer for the calculator datapath. It steps the user through operand A entry, operator select, operand B entry, ALU execution and result display, all driven by a single Enter button and a Clear button. It holds the captured operands, the 2-bit operator code and the result. It hands the ALU a one-cycle start strobe and waits for completion, with a timeout.

Parameters:
W, 8, operand/result width in bits
TIMEOUT, 255, max cycles spent in EXEC waiting for alu_done before error (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
btn_enter  in  1  Enter button level, already synchronised/debounced
btn_clr  in  1  Clear button level, already synchronised/debounced
sw_data  in  W  operand switches
sw_op  in  2  operator switches: 00 add, 01 sub, 10 mul, 11 div
alu_a  out  W  captured operand A (registered)
alu_b  out  W  captured operand B (registered)
alu_op  out  2  captured operator code (registered)
alu_start  out  1  one-cycle start strobe to ALU
alu_done  in  1  ALU completion strobe
alu_err  in  1  ALU error flag, valid with alu_done
alu_res  in  W  ALU result, valid with alu_done
disp_val  out  W  value for display driver (registered)
state_o  out  3  current state code
err  out  1  high while in ERR

Behaviour:
- State codes: A=0, OP=1, B=2, EXEC=3, SHOW=4, ERR=5. Codes 6 and 7 go to A on the next clock.
- Edge detect: enter_pulse = btn_enter & ~btn_prev, with btn_prev registered. The clear pulse is derived the same way from btn_clr.
- btn_prev and clr_prev reset to 1, so a button held through reset gives no pulse.
- Reset: state A; alu_a, alu_b, alu_op, result register and disp_val = 0; alu_start = 0; err = 0; timeout counter = 0.
- Clear pulse in any state: next state A, and alu_a, alu_b, alu_op and the result register are all zeroed. Clear beats Enter when both pulse in the same cycle.
- Transitions (all on enter_pulse unless noted):
  - A: capture sw_data into alu_a, go to OP.
  - OP: capture sw_op into alu_op, go to B.
  - B, div by zero (alu_op==11 and sw_data==0): capture sw_data into alu_b, go to ERR, no alu_start.
  - B, otherwise: capture sw_data into alu_b, go to EXEC, alu_start=1 in the first EXEC cycle only.
  - EXEC: Enter is ignored. The timeout counter clears on entry and increments each cycle.
  - EXEC, alu_done with alu_err=0: latch alu_res, go to SHOW.
  - EXEC, alu_done with alu_err=1: go to ERR.
  - EXEC, no alu_done by counter==TIMEOUT-1: go to ERR, so error entry occurs after exactly TIMEOUT EXEC cycles.
  - EXEC: if alu_done arrives in the expiry cycle, done wins.
  - SHOW: go to A; operands are retained until overwritten.
  - ERR: go to A.
- alu_done outside EXEC is ignored, including a late done after Clear or timeout.
- disp_val, registered and one cycle behind the state/switch inputs:
  - A or B: sw_data.
  - OP: zero-extended sw_op.
  - EXEC: alu_a.
  - SHOW: result register.
  - ERR: all ones.
- err = (state==ERR), registered. state_o reflects the state register directly.
- A held Enter produces exactly one transition; the button must be released and pressed again to advance further.
- Reset asserted mid-EXEC aborts the operation. alu_start is not reasserted.

Test Plan:
- After reset, enter pulses with sw_data=7, sw_op=00, sw_data=5 -> alu_a=7, alu_op=00, alu_b=5, alu_start high exactly 1 cycle. Then alu_done with alu_res=12 three cycles later -> state SHOW(4), disp_val=12 the cycle after, err=0.
- A=9, op=11, B=0 -> state ERR(5) directly from B, alu_start never asserted, err=1, disp_val=8'hFF. Then Enter -> state A, err=0.
- TIMEOUT=4, valid op, alu_done never asserted -> exactly 4 cycles in EXEC, then ERR. A later stray alu_done has no effect.
- btn_enter held high for 20 cycles in A -> only alu_a captured, state OP, no further advance.
- Clear and Enter pulse in the same cycle while in OP -> state A, alu_a=alu_b=alu_op=0.
- Reset with btn_enter held high, then release and press -> no transition during the hold, single A->OP transition on the re-press.
- Bonus: alu_done with alu_err=1 -> ERR.
